// File: rtl/core_bus_ctrl_pkg.sv
// Shared encodings and default timing for the EMC08 external bus controller.
// The default cycle counts are also used by core_mem_ctrl timing checks.
package core_bus_ctrl_pkg;

    localparam int ALE_CYCLES_DEF    = 1;
    localparam int STROBE_CYCLES_DEF = 2;
    localparam int CNT_W             = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_HOLD   = 3'd2,
        ST_STROBE = 3'd3,
        ST_END    = 3'd4
    } bus_state_t;

    typedef enum logic [1:0] {
        XFER_ROM_RD = 2'd0,
        XFER_RAM_RD = 2'd1,
        XFER_RAM_WR = 2'd2
    } xfer_type_t;

    // Requests are active-low; a write wins over a data read, which wins over a code read.
    function automatic xfer_type_t pick_type(input logic rom_rd_b, input logic ram_rd_b,
                                             input logic ram_wr_b);
        xfer_type_t t;
        if (!ram_wr_b)      t = XFER_RAM_WR;
        else if (!ram_rd_b) t = XFER_RAM_RD;
        else                t = XFER_ROM_RD;
        if (rom_rd_b && ram_rd_b && ram_wr_b) t = XFER_ROM_RD;
        return t;
    endfunction

endpackage

// File: rtl/core_bus_ctrl_wcnt.sv
// Loadable 4-bit wait-state down-counter; stops at zero and flags it.
module core_bus_ctrl_wcnt
    import core_bus_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/core_bus_ctrl.sv
// External bus controller: turns level requests from core_mem_ctrl into timed
// 8051-style cycles on P0/P2 with ALE, PSEN_b, RD_b and WR_b.
module core_bus_ctrl
    import core_bus_ctrl_pkg::*;
#(
    parameter int ALE_CYCLES    = ALE_CYCLES_DEF,
    parameter int STROBE_CYCLES = STROBE_CYCLES_DEF
) (
    input  logic        bus_ctrl_clk_i,
    input  logic        bus_ctrl_rst_i,
    input  logic [15:0] bus_ctrl_mem_addr_i,
    input  logic [7:0]  bus_ctrl_mem_data_i,
    input  logic        bus_ctrl_ext_rom_rd_b_i,
    input  logic        bus_ctrl_ext_ram_rd_b_i,
    input  logic        bus_ctrl_ext_ram_wr_b_i,
    output logic [7:0]  bus_ctrl_mem_data_o,
    output logic        bus_ctrl_mem_ea_b_o,
    output logic        bus_ctrl_busy_o,
    output logic        bus_ctrl_done_o,
    input  logic        bus_ctrl_ea_b_pad_i,
    input  logic [7:0]  bus_ctrl_p0_data_i,
    output logic [7:0]  bus_ctrl_p0_data_o,
    output logic        bus_ctrl_p0_oe_o,
    output logic [7:0]  bus_ctrl_p2_addr_o,
    output logic        bus_ctrl_ale_o,
    output logic        bus_ctrl_psen_b_o,
    output logic        bus_ctrl_rd_b_o,
    output logic        bus_ctrl_wr_b_o,
    output logic [2:0]  bus_ctrl_dbg_state_o
);

    // Out-of-range cycle counts would wrap the 4-bit counter; reject them at elaboration.
    if (ALE_CYCLES < 1 || ALE_CYCLES > 7 || STROBE_CYCLES < 1 || STROBE_CYCLES > 15)
    begin : g_param_check
        $error("core_bus_ctrl: ALE_CYCLES must be 1..7 and STROBE_CYCLES 1..15");
    end

    localparam logic [CNT_W-1:0] ALE_LOAD = CNT_W'(ALE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STR_LOAD = CNT_W'(STROBE_CYCLES - 1);

    // Request handshake: requests are active-low levels. A low request seen in IDLE
    // while armed is accepted on that edge; busy stays high until the done cycle and
    // the request must then go fully high for one cycle before another is accepted.

    bus_state_t       state_q, state_d;
    xfer_type_t       type_q, type_sel;
    logic [15:0]      addr_q, addr_sel;
    logic [7:0]       data_q, data_sel;
    logic             armed_q;
    logic             req_any, req_none, accept, capture;
    logic             cnt_load, cnt_zero;
    logic [CNT_W-1:0] cnt_load_val;

    logic             ale_d, psen_b_d, rd_b_d, wr_b_d, oe_d, done_d, busy_d;
    logic [7:0]       p0_d, p2_d;

    core_bus_ctrl_wcnt u_wcnt (
        .clk      (bus_ctrl_clk_i),
        .rst      (bus_ctrl_rst_i),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .zero     (cnt_zero)
    );

    assign req_none = bus_ctrl_ext_rom_rd_b_i & bus_ctrl_ext_ram_rd_b_i & bus_ctrl_ext_ram_wr_b_i;
    assign req_any  = ~req_none;
    assign accept   = (state_q == ST_IDLE) && armed_q && req_any;
    assign capture  = (state_q == ST_STROBE) && cnt_zero && (type_q != XFER_RAM_WR);

    // On the accept edge the live request is used, afterwards only the latched copy.
    assign addr_sel = accept ? bus_ctrl_mem_addr_i : addr_q;
    assign data_sel = accept ? bus_ctrl_mem_data_i : data_q;
    assign type_sel = accept ? pick_type(bus_ctrl_ext_rom_rd_b_i, bus_ctrl_ext_ram_rd_b_i,
                                         bus_ctrl_ext_ram_wr_b_i) : type_q;

    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_load_val = ALE_LOAD;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d  = ST_ADDR;
                    cnt_load = 1'b1;
                end
            end
            ST_ADDR: begin
                if (cnt_zero) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                state_d      = ST_STROBE;
                cnt_load     = 1'b1;
                cnt_load_val = STR_LOAD;
            end
            ST_STROBE: begin
                if (cnt_zero) state_d = ST_END;
            end
            ST_END:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Pin values are decoded from the next state so the registered pins line up with state_q.
    always_comb begin
        ale_d    = 1'b0;
        psen_b_d = 1'b1;
        rd_b_d   = 1'b1;
        wr_b_d   = 1'b1;
        oe_d     = 1'b0;
        done_d   = 1'b0;
        busy_d   = (state_d != ST_IDLE);
        p0_d     = bus_ctrl_p0_data_o;
        p2_d     = bus_ctrl_p2_addr_o;
        case (state_d)
            ST_ADDR: begin
                ale_d = 1'b1;
                oe_d  = 1'b1;
                p0_d  = addr_sel[7:0];
                p2_d  = addr_sel[15:8];
            end
            ST_HOLD: begin
                oe_d = 1'b1;
                p0_d = addr_sel[7:0];
            end
            ST_STROBE: begin
                case (type_sel)
                    XFER_RAM_WR: begin
                        wr_b_d = 1'b0;
                        oe_d   = 1'b1;
                        p0_d   = data_sel;
                    end
                    XFER_RAM_RD: rd_b_d   = 1'b0;
                    default:     psen_b_d = 1'b0;
                endcase
            end
            ST_END:  done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge bus_ctrl_clk_i) begin
        if (bus_ctrl_rst_i) begin
            state_q             <= ST_IDLE;
            armed_q             <= 1'b1;
            addr_q              <= '0;
            data_q              <= '0;
            type_q              <= XFER_ROM_RD;
            bus_ctrl_ale_o      <= 1'b0;
            bus_ctrl_psen_b_o   <= 1'b1;
            bus_ctrl_rd_b_o     <= 1'b1;
            bus_ctrl_wr_b_o     <= 1'b1;
            bus_ctrl_p0_oe_o    <= 1'b0;
            bus_ctrl_p0_data_o  <= '0;
            bus_ctrl_p2_addr_o  <= '0;
            bus_ctrl_mem_data_o <= '0;
            bus_ctrl_busy_o     <= 1'b0;
            bus_ctrl_done_o     <= 1'b0;
            bus_ctrl_mem_ea_b_o <= bus_ctrl_ea_b_pad_i;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q <= addr_sel;
                data_q <= data_sel;
                type_q <= type_sel;
            end
            if (state_q == ST_END) armed_q <= 1'b0;
            else if (req_none)     armed_q <= 1'b1;
            bus_ctrl_ale_o     <= ale_d;
            bus_ctrl_psen_b_o  <= psen_b_d;
            bus_ctrl_rd_b_o    <= rd_b_d;
            bus_ctrl_wr_b_o    <= wr_b_d;
            bus_ctrl_p0_oe_o   <= oe_d;
            bus_ctrl_p0_data_o <= p0_d;
            bus_ctrl_p2_addr_o <= p2_d;
            bus_ctrl_busy_o    <= busy_d;
            bus_ctrl_done_o    <= done_d;
            if (capture) bus_ctrl_mem_data_o <= bus_ctrl_p0_data_i;
        end
    end

    assign bus_ctrl_dbg_state_o = state_q;

endmodule
